// File: rtl/mig_app_responder.sv
// BRAM-backed responder for the MIG 7-series app_* interface: in-order command queue,
// separate write-data queue, fixed-latency read returns and a modelled calibration delay.
module mig_app_responder #(
  parameter int addr_width   = 24,
  parameter int data_width   = 128,
  parameter int depth_log2   = 10,
  parameter int read_latency = 4,
  parameter int queue_depth  = 4,
  parameter int calib_cycles = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [addr_width-1:0]   app_addr,
  input  logic [2:0]              app_cmd,
  input  logic                    app_en,
  output logic                    app_rdy,
  input  logic [data_width-1:0]   app_wdf_data,
  input  logic [data_width/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_wren,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [data_width-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete
);

  localparam int mask_width = data_width / 8;
  localparam int qaw        = $clog2(queue_depth);
  localparam int cmd_w      = 3 + depth_log2;
  localparam int wq_w       = data_width + mask_width;
  localparam int cal_w      = $clog2(calib_cycles + 1);
  localparam logic [qaw:0]   q_full   = (qaw + 1)'(queue_depth);
  localparam logic [qaw-1:0] ptr_one  = qaw'(1);
  localparam logic [2:0]     cmd_write = 3'b000;
  localparam logic [2:0]     cmd_read  = 3'b001;

  logic [cmd_w-1:0]      cmd_q [queue_depth];
  logic [qaw-1:0]        cmd_wr_ptr_reg, cmd_rd_ptr_reg;
  logic [qaw:0]          cmd_count_reg;
  logic [wq_w-1:0]       wq [queue_depth];
  logic [qaw-1:0]        wq_wr_ptr_reg, wq_rd_ptr_reg;
  logic [qaw:0]          wq_count_reg;
  logic [cal_w-1:0]      calib_count_reg;
  logic                  calib_done_reg;
  logic [data_width-1:0] mem [2**depth_log2];
  logic [data_width-1:0] ram_q_reg;
  logic [read_latency-1:0] rd_valid_pipe_reg;
  logic [data_width-1:0] rd_data_pipe_reg [read_latency-1];

  logic [cmd_w-1:0]      head;
  logic [2:0]            head_cmd;
  logic [depth_log2-1:0] head_addr;
  logic [wq_w-1:0]       wq_head;
  logic [data_width-1:0] wq_head_data;
  logic [mask_width-1:0] wq_head_mask;
  logic cmd_valid, wq_valid, wr_go, rd_go, cmd_pop, wq_pop, cmd_push, wq_push;
  logic unused_inputs;

  assign unused_inputs = &{1'b0, app_wdf_end, app_addr[addr_width-1:depth_log2]};

  assign head         = cmd_q[cmd_rd_ptr_reg];
  assign head_cmd     = head[cmd_w-1 -: 3];
  assign head_addr    = head[depth_log2-1:0];
  assign wq_head      = wq[wq_rd_ptr_reg];
  assign wq_head_data = wq_head[wq_w-1 -: data_width];
  assign wq_head_mask = wq_head[mask_width-1:0];

  // A write at the head blocks everything behind it until its data has arrived.
  assign cmd_valid = (cmd_count_reg != '0);
  assign wq_valid  = (wq_count_reg != '0);
  assign wr_go     = cmd_valid && (head_cmd == cmd_write) && wq_valid;
  assign rd_go     = cmd_valid && (head_cmd == cmd_read);
  assign cmd_pop   = cmd_valid && ((head_cmd != cmd_write) || wq_valid);
  assign wq_pop    = wr_go;

  assign app_rdy     = calib_done_reg && (cmd_count_reg < q_full);
  assign app_wdf_rdy = calib_done_reg && (wq_count_reg < q_full);
  assign cmd_push    = app_en && app_rdy;
  assign wq_push     = app_wdf_wren && app_wdf_rdy;

  assign init_calib_complete = calib_done_reg;
  assign app_rd_data_valid   = rd_valid_pipe_reg[read_latency-1];
  assign app_rd_data_end     = rd_valid_pipe_reg[read_latency-1];
  assign app_rd_data         = rd_data_pipe_reg[read_latency-2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calib_count_reg <= '0;
      calib_done_reg  <= 1'b0;
    end else if (!calib_done_reg) begin
      calib_count_reg <= calib_count_reg + cal_w'(1);
      calib_done_reg  <= (calib_count_reg == cal_w'(calib_cycles - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_count_reg  <= '0;
      wq_wr_ptr_reg  <= '0;
      wq_rd_ptr_reg  <= '0;
      wq_count_reg   <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + ptr_one;
      if (cmd_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + ptr_one;
      cmd_count_reg <= cmd_count_reg + (qaw + 1)'(cmd_push) - (qaw + 1)'(cmd_pop);
      if (wq_push)  wq_wr_ptr_reg <= wq_wr_ptr_reg + ptr_one;
      if (wq_pop)   wq_rd_ptr_reg <= wq_rd_ptr_reg + ptr_one;
      wq_count_reg <= wq_count_reg + (qaw + 1)'(wq_push) - (qaw + 1)'(wq_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_q[cmd_wr_ptr_reg] <= {app_cmd, app_addr[depth_log2-1:0]};
    if (wq_push)  wq[wq_wr_ptr_reg]     <= {app_wdf_data, app_wdf_mask};
  end

  // Reads and writes never pop together, so the registered read always sees prior writes.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < mask_width; i++) begin
        if (!wq_head_mask[i]) mem[head_addr][i*8 +: 8] <= wq_head_data[i*8 +: 8];
      end
    end
    if (rd_go) ram_q_reg <= mem[head_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid_pipe_reg <= '0;
    else          rd_valid_pipe_reg <= {rd_valid_pipe_reg[read_latency-2:0], rd_go};
  end

  genvar gi;
  generate
    for (gi = 0; gi < read_latency - 1; gi++) begin : g_rd_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     rd_data_pipe_reg[gi] <= '0;
        else if (gi == 0) rd_data_pipe_reg[gi] <= ram_q_reg;
        else              rd_data_pipe_reg[gi] <= rd_data_pipe_reg[(gi > 0) ? gi - 1 : 0];
      end
    end
  endgenerate

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: calibration, byte masks, queue stalls,
// aliasing, ordering and reset during in-flight reads.
module tb_mig_app_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [23:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mig_app_responder dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [23:0] addr);
    int n = 0;
    bit ok = 1'b0;
    app_cmd  = cmd;
    app_addr = addr;
    app_en   = 1'b1;
    while (!ok && n < 200) begin
      if (app_rdy) ok = 1'b1;
      tick();
      n++;
    end
    app_en = 1'b0;
    $display("[tb] cmd=%0d addr=%h accepted=%0d wait=%0d", cmd, addr, ok, n);
    check("cmd_accept", ok, 1);
  endtask

  task automatic send_data(input logic [127:0] data, input logic [15:0] mask);
    int n = 0;
    bit ok = 1'b0;
    app_wdf_data = data;
    app_wdf_mask = mask;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    while (!ok && n < 200) begin
      if (app_wdf_rdy) ok = 1'b1;
      tick();
      n++;
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    $display("[tb] wdata=%h mask=%h accepted=%0d wait=%0d", data, mask, ok, n);
    check("data_accept", ok, 1);
  endtask

  task automatic wait_valid(output int lat, output logic [127:0] data, output logic last);
    lat  = 0;
    data = '0;
    last = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (app_rd_data_valid) begin
        lat  = i;
        data = app_rd_data;
        last = app_rd_data_end;
        break;
      end
    end
    $display("[tb] read return lat=%0d data=%h", lat, data);
  endtask

  task automatic do_read(input string tag, input logic [23:0] addr, input logic [127:0] exp);
    int lat;
    logic [127:0] data;
    logic last;
    send_cmd(3'b001, addr);
    wait_valid(lat, data, last);
    check({tag, "_seen"}, (lat != 0), 1);
    check({tag, "_data"}, data, exp);
  endtask

  task automatic wait_calib(input string tag);
    int first = 0;
    int rdy_bad = 0;
    int pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (init_calib_complete && first == 0) first = i;
      if (app_rdy !== init_calib_complete) rdy_bad++;
      if (app_rd_data_valid) pulses++;
    end
    $display("[tb] %s calib first_high=%0d", tag, first);
    check({tag, "_calib_edge"}, first, 64);
    check({tag, "_rdy_track"}, rdy_bad, 0);
    check({tag, "_no_valid"}, pulses, 0);
  endtask

  localparam logic [127:0] d_a  = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] d_aa = {16{8'hAA}};

  initial begin
    int pulses;
    int lat;
    int n;
    logic [127:0] data;
    logic last;
    logic [127:0] got [2];

    reset_n      = 1'b0;
    app_en       = 1'b1;
    app_cmd      = 3'b001;
    app_addr     = '0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    repeat (3) tick();
    check("rst_app_rdy", app_rdy, 0);
    check("rst_wdf_rdy", app_wdf_rdy, 0);
    check("rst_valid", app_rd_data_valid, 0);
    check("rst_end", app_rd_data_end, 0);
    check("rst_calib", init_calib_complete, 0);
    check("rst_rd_data", app_rd_data, 0);

    // Calibration with app_en held high: exactly one read gets in, on edge 65.
    reset_n = 1'b1;
    wait_calib("boot");
    tick();
    app_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (app_rd_data_valid) pulses++;
    end
    check("boot_one_read", pulses, 1);

    // Full write then read with latency and end-strobe checks.
    send_cmd(3'b000, 24'h000005);
    send_data(d_a, 16'h0000);
    send_cmd(3'b001, 24'h000005);
    wait_valid(lat, data, last);
    check("rd_latency", lat, 4);
    check("rd_data", data, d_a);
    check("rd_end", last, 1);
    tick();
    check("rd_valid_drop", app_rd_data_valid, 0);
    check("rd_end_drop", app_rd_data_end, 0);

    // Byte mask: lower 8 bytes masked off.
    send_cmd(3'b000, 24'h000007);
    send_data({128{1'b1}}, 16'h0000);
    send_cmd(3'b000, 24'h000007);
    send_data(128'h0, 16'h00FF);
    do_read("mask", 24'h000007, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);

    // Four writes without data fill the command queue; a read behind them stalls.
    for (int i = 0; i < 4; i++) send_cmd(3'b000, 24'h000009);
    check("full_app_rdy", app_rdy, 0);
    check("full_wdf_rdy", app_wdf_rdy, 1);
    fork
      send_cmd(3'b001, 24'h000009);
      begin
        repeat (5) tick();
        check("stall_rdy", app_rdy, 0);
        check("stall_valid", app_rd_data_valid, 0);
        send_data({4{32'h1111_1111}}, 16'h0000);
        send_data({4{32'h2222_2222}}, 16'h0000);
        send_data({4{32'h3333_3333}}, 16'h0000);
        send_data({4{32'h4444_4444}}, 16'h0000);
      end
    join
    wait_valid(lat, data, last);
    check("stall_seen", (lat != 0), 1);
    check("stall_data", data, {4{32'h4444_4444}});

    // Two back-to-back reads return in command order.
    send_cmd(3'b001, 24'h000005);
    send_cmd(3'b001, 24'h000009);
    n = 0;
    got[0] = '0;
    got[1] = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (app_rd_data_valid) begin
        if (n < 2) got[n] = app_rd_data;
        n++;
      end
    end
    check("order_count", n, 2);
    check("order_first", got[0], d_a);
    check("order_second", got[1], {4{32'h4444_4444}});

    // Unused command code is consumed without side effects.
    send_cmd(3'b111, 24'h000005);
    do_read("noop", 24'h000005, d_a);

    // Data ahead of its command, then an aliased read address.
    send_data(d_aa, 16'h0000);
    repeat (3) tick();
    send_cmd(3'b000, 24'h000003);
    do_read("alias", 24'h000403, d_aa);

    // Reset with two reads in flight.
    send_cmd(3'b001, 24'h000005);
    send_cmd(3'b001, 24'h000007);
    tick();
    reset_n = 1'b0;
    #2;
    check("mid_rst_valid", app_rd_data_valid, 0);
    check("mid_rst_data", app_rd_data, 0);
    check("mid_rst_rdy", app_rdy, 0);
    check("mid_rst_calib", init_calib_complete, 0);
    tick();
    tick();
    reset_n = 1'b1;
    wait_calib("recal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
